// File: rtl/bit_serial_pkg.sv
// Shared types and sizing helpers for the bit-serial adder sequencer.
package bit_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of the bit counter; never narrower than one bit.
  function automatic int count_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Carry out of a full adder.
  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Single full-adder cell with a registered carry, stepped one bit per clock.
module serial_fa_cell
  import bit_serial_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic cin_init,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic s,
  output logic carry_q
);

  assign s = a ^ b ^ carry_q;

  // Carry flop: load seeds the carry-in, en advances it by one bit position.
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_q <= 1'b0;
    end else if (load) begin
      carry_q <= cin_init;
    end else if (en) begin
      carry_q <= majority(a, b, carry_q);
    end
  end

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: LSB-first through one full-adder cell.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// SHIFT | one result bit per cycle, WIDTH cycles
// DONE  | result presented, held until out_ready
module bit_serial_adder_ctrl
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = count_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] sum_sr;
  logic [WIDTH-1:0] sum_nxt;
  logic             fa_s;
  logic             fa_c;
  logic             accept;
  logic             shifting;

  assign accept   = (state == IDLE) && in_valid && in_ready;
  assign shifting = (state == SHIFT);
  // New bit enters at the top; low WIDTH-1 bits keep the partial result.
  assign sum_nxt  = {fa_s, sum_sr};

  serial_fa_cell u_fa (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .cin_init (op_sub),
    .en       (shifting),
    .a        (a_sr[0]),
    .b        (b_sr[0]),
    .s        (fa_s),
    .carry_q  (fa_c)
  );

  // Sequencer: operand load, per-bit shifting, result capture and handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr     <= op_a;
            b_sr     <= op_sub ? ~op_b : op_b;
            count    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_nxt[WIDTH-1:1];
          count  <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            // fa_c is the carry into the MSB on this final bit.
            sum       <= sum_nxt;
            carry_out <= majority(a_sr[0], b_sr[0], fa_c);
            overflow  <= fa_c ^ majority(a_sr[0], b_sr[0], fa_c);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Scoreboard bench for bit_serial_adder_ctrl with WIDTH=8 directed vectors.
module tb_bit_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;
  logic         busy;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic prev_ov  = 1'b0;

  bit_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency on out_valid rise, result compare on output handshake.
  always @(negedge clk) begin
    if (reset) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else chk("latency", cyc - q[0].acc, W);
      end
      if (out_valid && out_ready && q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("sum", {24'd0, sum}, {24'd0, e.s});
        chk("carry_out", {31'd0, carry_out}, {31'd0, e.c});
        chk("overflow", {31'd0, overflow}, {31'd0, e.v});
      end
      prev_ov = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands and wait for acceptance; optionally queue the expected result.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic [W-1:0] es, input logic ec, input logic ev, input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (push) q.push_back('{s: es, c: ec, v: ev, acc: cyc});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(in_ready && !out_valid) && n < 40) begin
      tick();
      n++;
    end
    if (!(in_ready && !out_valid)) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_sub    = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {carry_out, overflow}, 0);

    issue(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1); wait_idle();
    issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1); wait_idle();
    issue(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1); wait_idle();
    issue(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1); wait_idle();
    issue(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1); wait_idle();
    issue(8'hC8, 8'h32, 1'b1, 8'h96, 1'b1, 1'b0, 1'b1); wait_idle();

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    issue(8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_sum", sum, 8'h77);
      chk("bp_busy", busy, 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_busy", busy, 0);

    // Operand changes and in_valid pulses during SHIFT are ignored.
    issue(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
    op_a = 8'hFF; op_b = 8'hFF; op_sub = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1; op_a = 8'h80;
    tick();
    in_valid = 1'b0;
    wait_idle();

    // Reset during the 3rd SHIFT cycle aborts with no result.
    issue(8'hAA, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    issue(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1); wait_idle();

    repeat (3) tick();
    chk("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
